keypad_scanner: RTL and testbench

//  Scans a 4x5 active-low matrix keypad, debounces, and encodes one key press into the 5-bit

---
 rtl/keypad_pkg.sv | 58 +++++
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_col_scan.sv | 93 +++++++++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, state encodings and the key-index to calculator-code map
// used by the keypad scanner and its column scanner.
package keypad_pkg;

  localparam int N_ROWS        = 4;
  localparam int N_COLS        = 5;
  localparam int N_KEYS_MAPPED = 18;

  localparam logic [4:0] KEY_0    = 5'b00000;
  localparam logic [4:0] KEY_1    = 5'b00001;
  localparam logic [4:0] KEY_2    = 5'b00010;
  localparam logic [4:0] KEY_3    = 5'b00011;
  localparam logic [4:0] KEY_4    = 5'b00100;
  localparam logic [4:0] KEY_5    = 5'b00101;
  localparam logic [4:0] KEY_6    = 5'b00110;
  localparam logic [4:0] KEY_7    = 5'b00111;
  localparam logic [4:0] KEY_8    = 5'b01000;
  localparam logic [4:0] KEY_9    = 5'b01001;
  localparam logic [4:0] KEY_AC   = 5'b01010;
  localparam logic [4:0] KEY_RSVD = 5'b01011;
  localparam logic [4:0] KEY_NEG  = 5'b01100;
  localparam logic [4:0] KEY_DIV  = 5'b01101;
  localparam logic [4:0] KEY_MUL  = 5'b01110;
  localparam logic [4:0] KEY_SUB  = 5'b01111;
  localparam logic [4:0] KEY_ADD  = 5'b10000;
  localparam logic [4:0] KEY_EQ   = 5'b10001;

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} scan_res_t;

  // Unmapped indices never reach this function; they are filtered during the scan.
  function automatic logic [4:0] key_code(input logic [4:0] idx);
    logic [4:0] code;
    case (idx)
      5'd0:    code = KEY_0;
      5'd1:    code = KEY_1;
      5'd2:    code = KEY_2;
      5'd3:    code = KEY_3;
      5'd4:    code = KEY_4;
      5'd5:    code = KEY_5;
      5'd6:    code = KEY_6;
      5'd7:    code = KEY_7;
      5'd8:    code = KEY_8;
      5'd9:    code = KEY_9;
      5'd10:   code = KEY_AC;
      5'd11:   code = KEY_RSVD;
      5'd12:   code = KEY_NEG;
      5'd13:   code = KEY_DIV;
      5'd14:   code = KEY_MUL;
      5'd15:   code = KEY_SUB;
      5'd16:   code = KEY_ADD;
      5'd17:   code = KEY_EQ;
      default: code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus the key stream handed to the calculator.
// master = scanner side, slave = board/consumer side.
interface keypad_scanner_if;
  logic [keypad_pkg::N_ROWS-1:0] row_in;
  logic [keypad_pkg::N_COLS-1:0] col_out;
  logic [4:0]                    key_input;
  logic                          valid;

  modport master (input row_in, output col_out, output key_input, output valid);
  modport slave  (output row_in, input col_out, input key_input, input valid);
endinterface

// File: rtl/keypad_col_scan.sv
// Column walker: drives one column low per dwell, samples rows on the last dwell
// cycle and reports NONE/SINGLE/MULTI with a strobe at the end of each full scan.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic              scan_done,
  output scan_res_t         scan_kind,
  output logic [4:0]        scan_idx
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0]  div_reg;
  logic [2:0]        col_reg;
  logic [N_COLS-1:0] col_out_reg;
  logic [1:0]        acc_cnt_reg;
  logic [4:0]        acc_idx_reg;

  logic              dwell_end;
  logic              last_col;
  logic [N_ROWS-1:0] row_hit;
  logic [4:0]        row_idx [N_ROWS];
  logic [2:0]        col_hits;
  logic [4:0]        col_idx;
  logic [2:0]        hit_sum;
  logic [1:0]        total_cnt;
  logic [4:0]        total_idx;

  assign dwell_end = (div_reg == DIV_W'(SCAN_DIV - 1));
  assign last_col  = (col_reg == 3'(N_COLS - 1));

  // Unmapped positions (idx 18, 19) are masked so they never count as a press.
  genvar gi;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      assign row_idx[gi] = 5'(gi * N_COLS) + {2'b00, col_reg};
      assign row_hit[gi] = ~row_in[gi] && (row_idx[gi] < 5'(N_KEYS_MAPPED));
    end
  endgenerate

  always_comb begin
    col_hits = 3'd0;
    col_idx  = 5'd0;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if (row_hit[r]) begin
        col_hits = col_hits + 3'd1;
        col_idx  = row_idx[r];
      end
    end
    hit_sum   = {1'b0, acc_cnt_reg} + col_hits;
    total_cnt = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    total_idx = (acc_cnt_reg != 2'd0) ? acc_idx_reg : col_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_reg     <= '0;
      col_reg     <= 3'd0;
      col_out_reg <= {{(N_COLS-1){1'b1}}, 1'b0};
      acc_cnt_reg <= 2'd0;
      acc_idx_reg <= 5'd0;
    end else if (dwell_end) begin
      div_reg     <= '0;
      col_out_reg <= {col_out_reg[N_COLS-2:0], col_out_reg[N_COLS-1]};
      if (last_col) begin
        col_reg     <= 3'd0;
        acc_cnt_reg <= 2'd0;
        acc_idx_reg <= 5'd0;
      end else begin
        col_reg     <= col_reg + 3'd1;
        acc_cnt_reg <= total_cnt;
        acc_idx_reg <= total_idx;
      end
    end else begin
      div_reg <= div_reg + DIV_W'(1);
    end
  end

  // Result includes the col4 sample taken this very cycle, so the parent can
  // register its decision on the scan-ending edge.
  assign col_out   = col_out_reg;
  assign scan_done = dwell_end && last_col;
  assign scan_idx  = total_idx;
  assign scan_kind = (total_cnt == 2'd0) ? RES_NONE :
                     (total_cnt == 2'd1) ? RES_SINGLE : RES_MULTI;

endmodule

// File: rtl/keypad_scanner.sv
// 4x5 keypad scanner: debounces scan results and emits one valid strobe per press.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DLY     = 50,
  parameter int REPEAT_RATE    = 10
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  localparam int CNT_MAX0 = (DEBOUNCE_SCANS > REPEAT_DLY) ? DEBOUNCE_SCANS : REPEAT_DLY;
  localparam int CNT_MAX  = (CNT_MAX0 > REPEAT_RATE) ? CNT_MAX0 : REPEAT_RATE;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  logic [N_COLS-1:0] col_out;
  logic              scan_done;
  scan_res_t         scan_kind;
  logic [4:0]        scan_idx;

  state_t            state_reg;
  logic [4:0]        cand_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_inc;
  logic [4:0]        key_input_reg;
  logic              valid_reg;
`ifdef KEY_REPEAT_EN
  logic [CNT_W-1:0]  rep_cnt_reg;
  logic [CNT_W-1:0]  rep_inc;
  logic              rep_armed_reg;
  assign rep_inc = rep_cnt_reg + CNT_W'(1);
`endif

  assign cnt_inc = cnt_reg + CNT_W'(1);

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .row_in    (kp.row_in),
    .col_out   (col_out),
    .scan_done (scan_done),
    .scan_kind (scan_kind),
    .scan_idx  (scan_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cand_reg      <= 5'd0;
      cnt_reg       <= '0;
      key_input_reg <= 5'd0;
      valid_reg     <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_reg   <= '0;
      rep_armed_reg <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      if (scan_done) begin
        case (state_reg)
          S_IDLE: begin
            if (scan_kind == RES_SINGLE) begin
              cand_reg  <= scan_idx;
              cnt_reg   <= CNT_W'(1);
              state_reg <= S_DEB;
            end
          end
          S_DEB: begin
            if (scan_kind == RES_SINGLE && scan_idx == cand_reg) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                key_input_reg <= key_code(cand_reg);
                valid_reg     <= 1'b1;
                cnt_reg       <= '0;
                state_reg     <= S_HELD;
`ifdef KEY_REPEAT_EN
                rep_cnt_reg   <= '0;
                rep_armed_reg <= 1'b0;
`endif
              end else begin
                cnt_reg <= cnt_inc;
              end
            end else begin
              cnt_reg   <= '0;
              state_reg <= S_IDLE;
            end
          end
          S_HELD: begin
            if (scan_kind == RES_NONE) begin
              cnt_reg   <= CNT_W'(1);
              state_reg <= S_REL;
`ifdef KEY_REPEAT_EN
              rep_cnt_reg   <= '0;
              rep_armed_reg <= 1'b0;
            end else if (scan_kind == RES_SINGLE && scan_idx == cand_reg) begin
              // First repeat waits REPEAT_DLY scans, later ones REPEAT_RATE scans.
              if (rep_inc == (rep_armed_reg ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DLY))) begin
                valid_reg     <= 1'b1;
                rep_cnt_reg   <= '0;
                rep_armed_reg <= 1'b1;
              end else begin
                rep_cnt_reg <= rep_inc;
              end
            end else begin
              rep_cnt_reg <= '0;
`endif
            end
          end
          S_REL: begin
            if (scan_kind == RES_NONE) begin
              if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                cnt_reg   <= '0;
                state_reg <= S_IDLE;
              end else begin
                cnt_reg <= cnt_inc;
              end
            end else begin
              cnt_reg   <= '0;
              state_reg <= S_HELD;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign kp.col_out   = col_out;
  assign kp.key_input = key_input_reg;
  assign kp.valid     = valid_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x5 matrix model
// (SCAN_DIV=4, DEBOUNCE_SCANS=3: one full scan is 20 clk).
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] keys = '0;
  logic [3:0]  row_model;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int dbl_valid = 0;
  int key_chg = 0;
  logic       prev_valid = 1'b0;
  logic [4:0] prev_key = 5'd0;
  logic [4:0] codes[$];

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_DLY(6), .REPEAT_RATE(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_model = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c] && !kp.col_out[c]) row_model[r] = 1'b0;
  end
  assign kp.row_in = row_model;

  always @(negedge clk) begin
    if (rst) begin
      if (kp.valid) begin
        pulse_cnt++;
        codes.push_back(kp.key_input);
        if (prev_valid) dbl_valid++;
      end
      if (kp.key_input !== prev_key && !kp.valid) key_chg++;
    end
    prev_valid = kp.valid;
    prev_key   = kp.key_input;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Waits (bounded) for valid; returns cycles waited.
  task automatic wait_pulse(input int limit, output int lat);
    lat = 0;
    while (!kp.valid && lat < limit) begin
      tick(1);
      lat++;
    end
  endtask

  int base, lat, qbase;
  logic [4:0] exp_col, one_hot;
  logic [4:0] seq_idx [5];
  logic [4:0] seq_code [5];

  initial begin
    seq_idx  = '{5'd1, 5'd0, 5'd14, 5'd3, 5'd17};
    seq_code = '{5'b00001, 5'b00000, 5'b01110, 5'b00011, 5'b10001};

    // 1: reset, mid-scan reset, column walk
    #1 rst = 1'b0;
    tick(2);
    chk("rst_col", kp.col_out, 5'b11110);
    @(negedge clk); rst = 1'b1;
    tick(7);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_col", kp.col_out, 5'b11110);
    chk("async_rst_key", kp.key_input, 5'b00000);
    chk("async_rst_valid", kp.valid, 1'b0);
    tick(2);
    @(negedge clk); rst = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick(1);
      one_hot = 5'b00001 << ((j / 4) % 5);
      exp_col = ~one_hot;
      chk("col_walk", kp.col_out, exp_col);
    end

    // 2: idx1 held 15 scans
    base = pulse_cnt;
    keys[1] = 1'b1;
    wait_pulse(100, lat);
    chk("t2_latency_ok", lat <= 81, 1);
    chk("t2_key", kp.key_input, 5'b00001);
    tick(300 - lat);
    chk("t2_pulses", pulse_cnt - base, 1);
    keys[1] = 1'b0;
    tick(120);

    // 3: idx17 bouncing for 40 clk then stable
    base = pulse_cnt;
    for (int t = 0; t < 40; t++) begin
      keys[17] = ((t / 7) % 2) == 0;
      tick(1);
    end
    chk("t3_no_bounce_pulse", pulse_cnt - base, 0);
    keys[17] = 1'b1;
    tick(120);
    chk("t3_pulses", pulse_cnt - base, 1);
    chk("t3_key", kp.key_input, 5'b10001);
    keys[17] = 1'b0;
    tick(120);

    // 4: ghosting, then single remaining key, then short release
    base = pulse_cnt;
    keys[1] = 1'b1; keys[14] = 1'b1;
    tick(100);
    chk("t4_multi_no_pulse", pulse_cnt - base, 0);
    keys[1] = 1'b0;
    tick(120);
    chk("t4_pulses", pulse_cnt - base, 1);
    chk("t4_key", kp.key_input, 5'b01110);
    keys[14] = 1'b0;
    tick(40);
    keys[14] = 1'b1;
    tick(100);
    chk("t4_short_release", pulse_cnt - base, 1);
    keys = '0;
    tick(120);

    // 5: unmapped idx19
    base = pulse_cnt;
    keys[19] = 1'b1;
    tick(200);
    chk("t5_no_pulse", pulse_cnt - base, 0);
    chk("t5_key_kept", kp.key_input, 5'b01110);
    keys[19] = 1'b0;
    tick(60);

    // 6: press/release sequence, then reset during debounce
    qbase = codes.size();
    for (int k = 0; k < 5; k++) begin
      base = pulse_cnt;
      keys[seq_idx[k]] = 1'b1;
      tick(100);
      chk("t6_press_pulse", pulse_cnt - base, 1);
      chk("t6_key", kp.key_input, seq_code[k]);
      keys[seq_idx[k]] = 1'b0;
      tick(100);
      chk("t6_release_quiet", pulse_cnt - base, 1);
    end
    chk("t6_total", codes.size() - qbase, 5);
    for (int k = 0; k < 5; k++)
      if (qbase + k < codes.size())
        chk("t6_order", codes[qbase+k], seq_code[k]);

    base = pulse_cnt;
    keys[5] = 1'b1;
    tick(50);
    chk("t6_deb_no_pulse_yet", pulse_cnt - base, 0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_col", kp.col_out, 5'b11110);
    chk("t6_rst_key", kp.key_input, 5'b00000);
    chk("t6_rst_valid", kp.valid, 1'b0);
    tick(3);
    keys = '0;
    @(negedge clk); rst = 1'b1;
    tick(120);
    chk("t6_abort_no_pulse", pulse_cnt - base, 0);
    chk("t6_abort_key", kp.key_input, 5'b00000);

    chk("valid_single_cycle", dbl_valid, 0);
    chk("key_changes_only_on_valid", key_chg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
